hazard_ctrl: RTL

//  Pipeline sequencer for semiMIPS. Detects load-use and HI/LO (multiply/divide

---
 rtl/semimips_pkg.sv | 16 +
 rtl/hazard_ctrl_mdu_timer.sv | 73 +++++++
 rtl/hazard_ctrl.sv | 101 ++++++++++
 3 files changed

// File: rtl/semimips_pkg.sv
// semimips_pkg
//   Shared types and constants for the semiMIPS pipeline sequencer.
//   state_t      : MDU tracking state (RUN, MDU_BUSY)
//   REG_ZERO     : architectural $zero register index
//   MDU_LAT_DEF  : default multiply/divide latency in cycles
package semimips_pkg;

   typedef enum logic [0:0] {
      RUN      = 1'b0,
      MDU_BUSY = 1'b1
   } state_t;

   localparam logic [4:0] REG_ZERO    = 5'd0;
   localparam int         MDU_LAT_DEF = 32;

endpackage

// File: rtl/hazard_ctrl_mdu_timer.sv
// mdu_timer
//   Tracks how long the multiply/divide unit is busy. A start in RUN loads a
//   down-counter with MDU_LAT-1. The unit stays busy until the counter reaches
//   zero, so it is busy for exactly MDU_LAT cycles. On the way back to RUN it
//   emits a registered one-cycle done pulse.
// Ports
//   clk    in   rising-edge clock
//   rst_n  in   asynchronous active-low reset (aborts the timer, no done)
//   start  in   start an MDU op; ignored while already busy
//   busy   out  timer running
//   done   out  one-cycle pulse in the first cycle back in RUN
//
// state    | meaning
// ---------+------------------------------------------------
// RUN      | MDU idle, waiting for start
// MDU_BUSY | MDU op in flight, cnt counts down to zero
module mdu_timer
   import semimips_pkg::*;
#(
   parameter int MDU_LAT = MDU_LAT_DEF,
   parameter int CNT_W   = $clog2(MDU_LAT)
) (
   input  logic clk,
   input  logic rst_n,
   input  logic start,
   output logic busy,
   output logic done
);

   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MDU_LAT - 1);

   state_t           state, state_nxt;
   logic [CNT_W-1:0] cnt, cnt_nxt;
   logic             done_nxt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= RUN;
         cnt   <= '0;
         done  <= 1'b0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         done  <= done_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      done_nxt  = 1'b0;
      case (state)
         RUN: begin
            if (start) begin
               state_nxt = MDU_BUSY;
               cnt_nxt   = CNT_LOAD;
            end
         end
         MDU_BUSY: begin
            if (cnt == '0) begin
               state_nxt = RUN;
               done_nxt  = 1'b1;
            end else begin
               cnt_nxt = cnt - 1'b1;
            end
         end
         default: state_nxt = RUN;
      endcase
   end

   assign busy = (state == MDU_BUSY);

endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl
//   Pipeline sequencer for semiMIPS. Detects load-use and HI/LO hazards,
//   kills wrong-path fetches on jumps and taken branches, and drives the PC
//   and IF/ID enables plus the IF/ID and EX flushes. Counts stall cycles.
// Ports
//   clk, rst_n                     clock, async active-low reset
//   id_rs, id_rt                   source fields of the ID instruction
//   id_use_rs, id_use_rt           ID instruction reads rs / rt
//   id_use_hilo                    ID reads HI/LO or is itself an MDU op
//   id_jump                        ID instruction is j/jal/jr
//   ex_memread, ex_dst             EX load flag and destination register
//   ex_mdu_start                   EX instruction starts the MDU
//   ex_br_taken                    branch in EX resolved taken
//   pc_en, ifid_en                 PC and IF/ID write enables
//   ifid_flush, ex_flush           synchronous zeroing of IF/ID and EX control
//   mdu_busy, mdu_done             MDU timer running / completion pulse
//   stall_cnt                      saturating count of cycles with pc_en==0
module hazard_ctrl
   import semimips_pkg::*;
#(
   parameter int MDU_LAT = MDU_LAT_DEF,
   parameter int PERF_W  = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [4:0]        id_rs,
   input  logic [4:0]        id_rt,
   input  logic              id_use_rs,
   input  logic              id_use_rt,
   input  logic              id_use_hilo,
   input  logic              id_jump,
   input  logic              ex_memread,
   input  logic [4:0]        ex_dst,
   input  logic              ex_mdu_start,
   input  logic              ex_br_taken,
   output logic              pc_en,
   output logic              ifid_en,
   output logic              ifid_flush,
   output logic              ex_flush,
   output logic              mdu_busy,
   output logic              mdu_done,
   output logic [PERF_W-1:0] stall_cnt
);

   localparam int CNT_W = $clog2(MDU_LAT);

   logic lu, hl, stall;

   mdu_timer #(
      .MDU_LAT (MDU_LAT),
      .CNT_W   (CNT_W)
   ) u_mdu_timer (
      .clk   (clk),
      .rst_n (rst_n),
      .start (ex_mdu_start),
      .busy  (mdu_busy),
      .done  (mdu_done)
   );

   // Writes to $zero never create a dependency.
   assign lu = ex_memread && (ex_dst != REG_ZERO) &&
               ((id_use_rs && (id_rs == ex_dst)) || (id_use_rt && (id_rt == ex_dst)));

   // An MDU op entering the timer this cycle already blocks HI/LO readers.
   assign hl = id_use_hilo && (mdu_busy || ex_mdu_start);

   // A taken branch kills the ID instruction, so its hazards are moot.
   assign stall = (lu || hl) && !ex_br_taken;

   always_comb begin
      pc_en      = 1'b1;
      ifid_en    = 1'b1;
      ifid_flush = 1'b0;
      ex_flush   = 1'b0;
      if (!rst_n) begin
         pc_en      = 1'b0;
         ifid_en    = 1'b0;
         ifid_flush = 1'b1;
         ex_flush   = 1'b1;
      end else if (ex_br_taken) begin
         ifid_flush = 1'b1;
         ex_flush   = 1'b1;
      end else if (stall) begin
         // Jump held in ID is kept; it is re-evaluated once the stall clears.
         pc_en    = 1'b0;
         ifid_en  = 1'b0;
         ex_flush = 1'b1;
      end else if (id_jump) begin
         ifid_flush = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_cnt <= '0;
      end else if (!pc_en && (stall_cnt != '1)) begin
         stall_cnt <= stall_cnt + 1'b1;
      end
   end

endmodule
